uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART shift register (SIPO, 10-bit frame = 8 data LSB-first + parity + stop).
- Detects and qualifies the start bit, times mid-bit sampling from an oversampled baud tick, and drives the SIPO enables.
- After the 10th bit, checks parity and stop, then presents a byte with valid/error flags.
- Sits between the baud generator and the SIPO; its outputs feed the RX host interface.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_filter.sv | 56 +++++
 rtl/uart_rx_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive controller files.
//   state_t    : receive sequencer states
//   FRAME_BITS : bits per frame (8 data + parity + stop)
//   DATA_BITS  : data bits per frame
//   PARITY_IDX : parity bit position in the SIPO frame
//   STOP_IDX   : stop bit position in the SIPO frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CHECK,
    WAIT_HIGH
  } state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned PARITY_IDX = 8;
  localparam int unsigned STOP_IDX   = 9;

endpackage

// File: rtl/uart_rx_filter.sv
// uart_rx_filter: synchronises the raw serial line and produces the filtered
// line value used by the receive sequencer and the SIPO.
// Optional macro UART_RX_MAJORITY_EN: when defined, rx_bit is the majority of
// the last three synchronised samples taken on baud_tick (rejects one-tick
// glitches, adds one baud_tick of delay). When undefined, rx_bit is the
// synchroniser output.
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   baud_tick in  oversampled baud pulse
//   rx_in     in  raw asynchronous serial line (idle high)
//   rx_bit    out filtered line value (1 after reset)
module uart_rx_filter
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic rx_in,
  output logic rx_bit
);

  logic [1:0] sync;

  // Reset to the idle-high level so no false start is seen after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
    end else begin
      sync <= {sync[0], rx_in};
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '1;
    end else if (baud_tick) begin
      hist <= {hist[1:0], sync[1]};
    end
  end

  always_comb begin
    rx_bit = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  end
`else
  logic unused_tick;

  always_comb begin
    unused_tick = baud_tick;
    rx_bit      = sync[1];
  end
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for a 10-bit UART frame
// (8 data LSB-first, parity, stop) captured by an external SIPO.
// Optional macro UART_RX_MAJORITY_EN selects the majority-vote line filter.
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   baud_tick   in  one-clk pulse at OVERSAMPLE x baud rate
//   rx_in       in  raw serial line, idle high
//   frame_in    in  SIPO contents: [7:0] data, [8] parity, [9] stop
//   rx_bit      out filtered line value, feeds the SIPO serial input
//   run_shift   out SIPO enable, high throughout DATA
//   sample_done out one-clk SIPO shift strobe at each mid-bit
//   data_out    out last received byte, held until the next frame
//   data_valid  out one-clk pulse when data_out updates
//   parity_err  out parity error, qualified by data_valid
//   frame_err   out stop bit was 0, qualified by data_valid
//   busy        out high in any state other than IDLE
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  rx_in,
  input  logic [FRAME_BITS-1:0] frame_in,
  output logic                  rx_bit,
  output logic                  run_shift,
  output logic                  sample_done,
  output logic [DATA_BITS-1:0]  data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    BIT_END  = 4'(FRAME_BITS);

  state_t               state, state_nxt;
  logic [TW-1:0]        tick_cnt, tick_nxt;
  logic [3:0]           bit_idx, bit_nxt;
  logic                 sample_nxt, valid_nxt, perr_nxt, ferr_nxt;
  logic [DATA_BITS-1:0] data_nxt;

  uart_rx_filter u_filter (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx_in     (rx_in),
    .rx_bit    (rx_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      sample_done <= 1'b0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      data_out    <= '0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_nxt;
      bit_idx     <= bit_nxt;
      sample_done <= sample_nxt;
      data_valid  <= valid_nxt;
      parity_err  <= perr_nxt;
      frame_err   <= ferr_nxt;
      data_out    <= data_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    bit_nxt    = bit_idx;
    sample_nxt = 1'b0;
    valid_nxt  = 1'b0;
    perr_nxt   = 1'b0;
    ferr_nxt   = 1'b0;
    data_nxt   = data_out;

    case (state)
      IDLE: begin
        if (baud_tick && !rx_bit) begin
          state_nxt = START;
          tick_nxt  = '0;
        end
      end

      START: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = rx_bit ? IDLE : DATA;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        // The exit test does not wait for baud_tick: the 10th shift lands in
        // the SIPO on the edge that enters CHECK.
        if (bit_idx == BIT_END) begin
          state_nxt = CHECK;
          tick_nxt  = '0;
          bit_nxt   = '0;
        end else if (baud_tick) begin
          if (tick_cnt == TICK_MAX) begin
            tick_nxt   = '0;
            bit_nxt    = bit_idx + 1'b1;
            sample_nxt = 1'b1;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end

      CHECK: begin
        data_nxt  = frame_in[DATA_BITS-1:0];
        perr_nxt  = (^frame_in[PARITY_IDX:0]) ^ (PARITY_ODD != 0);
        ferr_nxt  = ~frame_in[STOP_IDX];
        valid_nxt = 1'b1;
        state_nxt = frame_in[STOP_IDX] ? IDLE : WAIT_HIGH;
      end

      WAIT_HIGH: begin
        // Holding here until the line idles keeps a break from retriggering.
        if (baud_tick && rx_bit) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    run_shift = (state == DATA);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl with a behavioural
// SIPO per instance. A second instance runs with odd parity on the same line.
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, tick every 4 clk

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx_in = 1'b1;

  logic [9:0] sipo = '0;
  logic       rx_bit, run_shift, sample_done, data_valid, parity_err, frame_err, busy;
  logic [7:0] data_out;

  logic [9:0] sipo_o = '0;
  logic       rx_bit_o, run_shift_o, sample_done_o, data_valid_o, parity_err_o, frame_err_o, busy_o;
  logic [7:0] data_out_o;

  int checks = 0;
  int errors = 0;

  // Monitor state: written only by the monitor block.
  int         cyc = 0;
  int         last_sd = 0;
  int         sd_cnt = 0;
  int         rs_cnt = 0;
  int         busy_cnt = 0;
  int         dv_long = 0;
  logic       dv_prev = 1'b0;
  logic [9:0] got_q[$];
  int         lat_q[$];
  logic [9:0] got_odd_q[$];

  // Scoreboard: expected {data, parity_err, frame_err}, pushed at stimulus.
  logic [9:0] exp_q[$];
  int         rd = 0;

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  uart_rx_ctrl #(.OVERSAMPLE(16), .PARITY_ODD(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rx_in       (rx_in),
    .frame_in    (sipo),
    .rx_bit      (rx_bit),
    .run_shift   (run_shift),
    .sample_done (sample_done),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  uart_rx_ctrl #(.OVERSAMPLE(16), .PARITY_ODD(1)) dut_odd (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rx_in       (rx_in),
    .frame_in    (sipo_o),
    .rx_bit      (rx_bit_o),
    .run_shift   (run_shift_o),
    .sample_done (sample_done_o),
    .data_out    (data_out_o),
    .data_valid  (data_valid_o),
    .parity_err  (parity_err_o),
    .frame_err   (frame_err_o),
    .busy        (busy_o)
  );

  // Behavioural SIPOs: right shift so the first received bit ends in [0].
  always @(posedge clk) begin
    if (run_shift && sample_done) sipo <= {rx_bit, sipo[9:1]};
    if (run_shift_o && sample_done_o) sipo_o <= {rx_bit_o, sipo_o[9:1]};
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sample_done) begin
      sd_cnt  <= sd_cnt + 1;
      last_sd <= cyc;
    end
    if (run_shift) rs_cnt <= rs_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (data_valid) begin
      got_q.push_back({data_out, parity_err, frame_err});
      lat_q.push_back(cyc - last_sd);
    end
    if (data_valid && dv_prev) dv_long <= dv_long + 1;
    dv_prev <= data_valid;
    if (data_valid_o) got_odd_q.push_back({data_out_o, parity_err_o, frame_err_o});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic wait_dv(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b req 0", busy); end
    checks++; if (run_shift !== 1'b0) begin errors++; $display("FAIL reset_run_shift got %b req 0", run_shift); end
    checks++; if (sample_done !== 1'b0) begin errors++; $display("FAIL reset_sample_done got %b req 0", sample_done); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b req 0", data_valid); end
    checks++; if ({parity_err, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_err_flags got %b req 00", {parity_err, frame_err}); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h req 00", data_out); end
    checks++; if (rx_bit !== 1'b1) begin errors++; $display("FAIL reset_rx_bit got %b req 1", rx_bit); end
    rst = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_basic();
    int sd0, lat;
    bit ok;
    logic [9:0] e, g;
    sd0 = sd_cnt;
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_dv(rd + 1, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      errors++; $display("FAIL basic_dv got no data_valid req one pulse");
    end else begin
      g = got_q[rd]; lat = lat_q[rd]; rd++;
      checks++; if (g !== e) begin errors++; $display("FAIL basic_frame got %h/%b/%b req %h/%b/%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d req 2", lat); end
    end
    checks++; if (sd_cnt - sd0 !== 10) begin errors++; $display("FAIL basic_sample_count got %0d req 10", sd_cnt - sd0); end
    checks++; if (dv_long !== 0) begin errors++; $display("FAIL basic_dv_width got %0d long pulses req 0", dv_long); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b req 0", busy); end
  endtask

  task automatic test_parity();
    int rd_odd;
    bit ok;
    logic [9:0] e, g;
    rd_odd = got_odd_q.size();
    exp_q.push_back({8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b1, 1'b1);
    send_bit(1'b1);
    wait_dv(rd + 1, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      errors++; $display("FAIL parity_dv got no data_valid req one pulse");
    end else begin
      g = got_q[rd]; rd++;
      checks++; if (g !== e) begin errors++; $display("FAIL parity_even got %h/%b/%b req %h/%b/%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
    end
    checks++;
    if (got_odd_q.size() <= rd_odd) begin
      errors++; $display("FAIL parity_odd_dv got no data_valid req one pulse");
    end else begin
      g = got_odd_q[rd_odd];
      checks++; if (g !== {8'h3C, 1'b0, 1'b0}) begin errors++; $display("FAIL parity_odd got %h/%b/%b req 3c/0/0", g[9:2], g[1], g[0]); end
    end
  endtask

  task automatic test_break();
    int sd0;
    bit ok;
    logic [9:0] e, g;
    sd0 = sd_cnt;
    exp_q.push_back({8'h55, 1'b0, 1'b1});
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40 * 4) @(negedge clk);
    wait_dv(rd + 1, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      errors++; $display("FAIL break_dv got no data_valid req one pulse");
    end else begin
      g = got_q[rd]; rd++;
      checks++; if (g !== e) begin errors++; $display("FAIL break_frame got %h/%b/%b req %h/%b/%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_low got %b req 1", busy); end
    checks++; if (sd_cnt - sd0 !== 10) begin errors++; $display("FAIL break_no_retrigger got %0d samples req 10", sd_cnt - sd0); end
    checks++; if (got_q.size() !== rd) begin errors++; $display("FAIL break_extra_dv got %0d frames req %0d", got_q.size(), rd); end
    rx_in = 1'b1;
    repeat (24) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release got busy %b req 0", busy); end
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_false_start();
    int sd0, rs0, b0;
    sd0 = sd_cnt; rs0 = rs_cnt; b0 = busy_cnt;
    rx_in = 1'b0;
    repeat (4 * 4) @(negedge clk);
    rx_in = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (busy_cnt == b0) begin errors++; $display("FAIL false_start_entered got busy never req busy seen"); end
    checks++; if (sd_cnt !== sd0) begin errors++; $display("FAIL false_start_sample got %0d req 0", sd_cnt - sd0); end
    checks++; if (rs_cnt !== rs0) begin errors++; $display("FAIL false_start_run_shift got %0d cycles req 0", rs_cnt - rs0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_idle got busy %b req 0", busy); end
    checks++; if (got_q.size() !== rd) begin errors++; $display("FAIL false_start_dv got %0d frames req %0d", got_q.size(), rd); end
  endtask

  task automatic test_abort();
    int sd0;
    bit ok;
    logic [9:0] e, g;
    sd0 = sd_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    checks++; if (sd_cnt - sd0 !== 5) begin errors++; $display("FAIL abort_progress got %0d samples req 5", sd_cnt - sd0); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, run_shift, sample_done, data_valid} !== 4'b0000) begin errors++; $display("FAIL abort_ctrl got %b req 0000", {busy, run_shift, sample_done, data_valid}); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL abort_data_out got %h req 00", data_out); end
    checks++; if ({parity_err, frame_err, rx_bit} !== 3'b001) begin errors++; $display("FAIL abort_flags got %b req 001", {parity_err, frame_err, rx_bit}); end
    rst = 1'b0;
    send_bit(1'b1);
    checks++; if (got_q.size() !== rd) begin errors++; $display("FAIL abort_no_dv got %0d frames req %0d", got_q.size(), rd); end
    exp_q.push_back({8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_dv(rd + 1, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      errors++; $display("FAIL abort_recover_dv got no data_valid req one pulse");
    end else begin
      g = got_q[rd]; rd++;
      checks++; if (g !== e) begin errors++; $display("FAIL abort_recover got %h/%b/%b req %h/%b/%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int sd0;
    bit ok;
    logic [9:0] e, g;
    sd0 = sd_cnt;
    exp_q.push_back({8'h00, 1'b0, 1'b0});
    exp_q.push_back({8'hFF, 1'b0, 1'b0});
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_dv(rd + 2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_dv got %0d frames req %0d", got_q.size() - rd, 2);
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        g = got_q[rd]; rd++;
        checks++; if (g !== e) begin errors++; $display("FAIL b2b_frame%0d got %h/%b/%b req %h/%b/%b", k, g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
      end
    end
    checks++; if (sd_cnt - sd0 !== 20) begin errors++; $display("FAIL b2b_sample_count got %0d req 20", sd_cnt - sd0); end
    checks++; if (dv_long !== 0) begin errors++; $display("FAIL b2b_dv_width got %0d long pulses req 0", dv_long); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_false_start();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
